uart_matrix_loader: RTL
=======================

UART_MATRIX_LOADER -- requirements
Module: uart_matrix_loader

Interface
REQ-001 Parameter: DIM, 4, matrix dimension; each of matrices A and B is DIM x DIM.
REQ-002 Parameter: TIMEOUT, 50000, max clk cycles allowed between received bytes during a load.
REQ-003 clk  input  1  sole clock, shared with the 8-bit UART receiver.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 rx_done  input  1  single-cycle strobe, byte valid on rx_data.
REQ-007 rx_data  input  8  received byte.
REQ-008 rx_err  input  1  receiver stop-bit error strobe.
REQ-009 rx_en  output  1  receiver enable.
REQ-010 wr_en  output  1  single-cycle matrix-buffer write strobe.
REQ-011 wr_sel  output  1  target matrix: 0 = A, 1 = B.
REQ-012 wr_addr  output  AW  word address, row-major; AW = clog2(DIM*DIM), minimum 1.
REQ-013 wr_data  output  16  assembled word.
REQ-014 busy  output  1  load in progress.
REQ-015 load_done  output  1  single-cycle pulse on successful load.
REQ-016 err_code  output  2  00 none, 01 bad header, 10 checksum mismatch, 11 framing or timeout; sticky.

Function
REQ-017 Frame format SHALL be:
- header byte 0xA5
- 2*DIM*DIM words (all of A, then all of B), each sent low byte first
- one checksum byte equal to the XOR of all data bytes; header excluded.
REQ-018 States SHALL be IDLE, HDR, LO, HI, CSUM.
REQ-019 IDLE: rx_en=0, busy=0; start -> HDR; err_code cleared to 00, word counter, address, wr_sel and checksum accumulator cleared.
REQ-020 Non-IDLE states: rx_en=1, busy=1.
REQ-021 HDR: rx_done with 0xA5 -> LO; any other byte -> err_code=01, go to IDLE.
REQ-022 LO: rx_done latches the low byte, XORs it into the accumulator, go to HI.
REQ-023 HI, on rx_done:
- XOR the byte into the accumulator
- next cycle: wr_en=1, wr_data={byte, low}, with the current wr_sel/wr_addr
- go to LO, or to CSUM if this was word 2*DIM*DIM-1.
REQ-024 Write latency SHALL be exactly 1 cycle after the high-byte rx_done; wr_en otherwise 0.
REQ-025 wr_addr SHALL increment after each write; after address DIM*DIM-1 with wr_sel=0, it wraps to 0 and wr_sel becomes 1.
REQ-026 CSUM: rx_done with byte == accumulator -> load_done=1 for one cycle, go to IDLE; mismatch -> err_code=10, go to IDLE.
REQ-027 rx_err in any non-IDLE state -> err_code=11, go to IDLE; if rx_done and rx_err coincide, rx_err SHALL win and the byte is discarded.
REQ-028 Timeout counter: cleared on entering HDR and on every rx_done; increments each cycle in non-IDLE states; reaching TIMEOUT -> err_code=11, go to IDLE.
REQ-029 start while busy SHALL be ignored; rx_done/rx_err in IDLE SHALL be ignored.
REQ-030 Error exit SHALL NOT assert load_done; writes already issued are not retracted.
REQ-031 err_code SHALL hold its value until the next accepted start or rst.

Reset
REQ-032 rst SHALL force on the next clk edge:
- state IDLE; rx_en=0, busy=0, wr_en=0, load_done=0
- wr_sel=0, wr_addr=0, wr_data=0, err_code=00
- accumulator and counters 0.
REQ-033 rst mid-load SHALL abandon the frame with no further writes and no load_done.

Verification (DIM=2)
REQ-034 start; bytes A5, then 01 00, 02 00, ... 08 00 (data low bytes 01..08), checksum 08 -> 8 writes: wr_sel=0, addr 0..3, data 0001..0004; then wr_sel=1, addr 0..3, data 0005..0008; load_done pulses once; err_code=00.
REQ-035 start; first byte 5A -> no writes, err_code=01, busy=0.
REQ-036 Valid frame with checksum byte FF -> 8 writes, then err_code=10, no load_done.
REQ-037 start, A5, 34, 12 (write 1234 to A[0]), then rx_err on the next byte -> err_code=11, exactly 1 write.
REQ-038 TIMEOUT=100: start, A5, then silence -> err_code=11 exactly 100 cycles after the header rx_done; start pulse during the load ignored; rst asserted after 3 words -> all outputs at reset values, no further writes.

Source files
------------

// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader: receives a framed pair of DIM x DIM 16-bit matrices
// over a byte-wide UART receiver interface and streams each assembled word
// to a matrix buffer. The frame is a 0xA5 header, then all words of A and
// then all words of B (low byte first), then an XOR checksum over the data
// bytes. Framing errors, timeouts, bad headers and checksum mismatches abort
// the load and leave a sticky error code.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | receiver disabled, waiting for start
// HDR   | waiting for the 0xA5 header byte
// LO    | waiting for the low byte of the next word
// HI    | waiting for the high byte; a write is issued on the next cycle
// CSUM  | waiting for the checksum byte
module uart_matrix_loader #(
    parameter  int DIM     = 4,
    parameter  int TIMEOUT = 50000,
    localparam int AW      = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rx_done,
    input  logic [7:0]    rx_data,
    input  logic          rx_err,
    output logic          rx_en,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          load_done,
    output logic [1:0]    err_code
);

    localparam int WORDS = 2 * DIM * DIM;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DIM * DIM - 1);
    localparam logic [TW-1:0]  TMR_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [7:0]     HDR_BYTE  = 8'hA5;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_HDR   = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;
    localparam logic [1:0] ERR_FRAME = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LO,
        HI,
        CSUM
    } state_t;

    state_t         state;
    logic [7:0]     lo_byte;
    logic [7:0]     csum;
    logic [WCW-1:0] word_cnt;
    // Inter-byte timer counts down from TIMEOUT-1; expiry is the cycle it
    // is already at zero with no byte arriving, i.e. TIMEOUT cycles after
    // the last reload.
    logic [TW-1:0]  tmr;

    // Frame sequencing, write generation, address tracking and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_en     <= 1'b0;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            wr_sel    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_done <= 1'b0;
            err_code  <= ERR_NONE;
            lo_byte   <= '0;
            csum      <= '0;
            word_cnt  <= '0;
            tmr       <= '0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;

            // Address advances once the write presenting it has been issued.
            if (wr_en) begin
                if (wr_addr == LAST_ADDR) begin
                    wr_addr <= '0;
                    wr_sel  <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + AW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR;
                        rx_en    <= 1'b1;
                        busy     <= 1'b1;
                        err_code <= ERR_NONE;
                        word_cnt <= '0;
                        wr_addr  <= '0;
                        wr_sel   <= 1'b0;
                        csum     <= '0;
                        tmr      <= TMR_LOAD;
                    end
                end
                default: begin
                    if (rx_err) begin
                        // A framing error discards any byte strobed with it.
                        err_code <= ERR_FRAME;
                        state    <= IDLE;
                        rx_en    <= 1'b0;
                        busy     <= 1'b0;
                    end else if (rx_done) begin
                        tmr <= TMR_LOAD;
                        case (state)
                            HDR: begin
                                if (rx_data == HDR_BYTE) begin
                                    state <= LO;
                                end else begin
                                    err_code <= ERR_HDR;
                                    state    <= IDLE;
                                    rx_en    <= 1'b0;
                                    busy     <= 1'b0;
                                end
                            end
                            LO: begin
                                lo_byte <= rx_data;
                                csum    <= csum ^ rx_data;
                                state   <= HI;
                            end
                            HI: begin
                                csum     <= csum ^ rx_data;
                                wr_en    <= 1'b1;
                                wr_data  <= {rx_data, lo_byte};
                                word_cnt <= word_cnt + WCW'(1);
                                state    <= (word_cnt == LAST_WORD) ? CSUM : LO;
                            end
                            CSUM: begin
                                if (rx_data == csum) begin
                                    load_done <= 1'b1;
                                end else begin
                                    err_code <= ERR_CSUM;
                                end
                                state <= IDLE;
                                rx_en <= 1'b0;
                                busy  <= 1'b0;
                            end
                            default: begin
                                state <= IDLE;
                                rx_en <= 1'b0;
                                busy  <= 1'b0;
                            end
                        endcase
                    end else if (tmr == '0) begin
                        err_code <= ERR_FRAME;
                        state    <= IDLE;
                        rx_en    <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
            endcase
        end
    end

endmodule
